// File: rtl/glitch_pkg.sv
// glitch_pkg: shared sweep state encoding, default widths and pipeline constants
package glitch_pkg;
  typedef enum logic [2:0] {IDLE, TGT_RST, WAIT_TRIG, BURST, OBSERVE, NEXT, DONE} sweep_state_t;
  localparam int DELAY_W_DEF = 64;
  localparam int FORM_W_DEF = 64;
  localparam int TIMER_W = 64;
  localparam int BURST_PIPE_LAT = 2;
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter shared by all timed sweep states, expired when it reaches zero
module cycle_timer
  import glitch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);
  logic [TIMER_W-1:0] cnt;
  assign expired = cnt == '0;
  // reload on state entry, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !expired) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl: delay-sweep campaign sequencer for form_glitcher (GLITCH_STOP_ON_HIT_EN ends the sweep on the first hit)
module glitch_sweep_ctrl
  import glitch_pkg::*;
#(
  parameter int DELAY_W      = DELAY_W_DEF,
  parameter int FORM_W       = FORM_W_DEF,
  parameter int RST_CYCLES   = 1000,
  parameter int TRIG_TIMEOUT = 1_000_000,
  parameter int OBS_CYCLES   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] cfg_delay_start,
  input  logic [31:0]        cfg_delay_step,
  input  logic [15:0]        cfg_delay_count,
  input  logic [7:0]         cfg_repeats,
  input  logic [FORM_W-1:0]  cfg_form,
  input  logic               target_trig,
  input  logic               target_ok,
  input  logic               target_fault,
  output logic               target_rst_n,
  output logic               glitch_trig,
  output logic [DELAY_W-1:0] glitch_delay,
  output logic [FORM_W-1:0]  glitch_form,
  output logic               busy,
  output logic               done,
  output logic [15:0]        hit_count,
  output logic [15:0]        timeout_count,
  output logic [DELAY_W-1:0] last_hit_delay
);
  sweep_state_t state, state_nx;
  logic [31:0] step;
  logic [15:0] pts, pt;
  logic [7:0] reps_m1, rep;
  logic expired, last_rep, last_pt, hit, to_inc, tmr_load, tmr_en;
  logic [TIMER_W-1:0] tmr_val;
  logic [TIMER_W+1:0] burst_len;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign target_rst_n = !(state == TGT_RST && !abort);
  assign glitch_trig = target_trig && state == WAIT_TRIG && !abort;
  assign last_rep = rep == reps_m1;
  assign last_pt = last_rep && (pt + 16'd1 == pts);
  assign hit = state == OBSERVE && target_fault && !abort;
  assign to_inc = !abort && ((state == WAIT_TRIG && !target_trig && expired)
                          || (state == OBSERVE && !target_fault && !target_ok && expired));
  assign burst_len = (TIMER_W+2)'(glitch_delay) + (TIMER_W+2)'(FORM_W) + (TIMER_W+2)'(BURST_PIPE_LAT - 1);
  assign tmr_load = state_nx != state;
  assign tmr_en = state inside {TGT_RST, WAIT_TRIG, BURST, OBSERVE};
  assign tmr_val = state_nx == TGT_RST   ? TIMER_W'(RST_CYCLES - 1)
                 : state_nx == WAIT_TRIG ? TIMER_W'(TRIG_TIMEOUT - 1)
                 : state_nx == BURST     ? (|burst_len[TIMER_W+1:TIMER_W] ? '1 : burst_len[TIMER_W-1:0])
                 :                         TIMER_W'(OBS_CYCLES - 1);
  cycle_timer u_timer (
    .clk(clk), .rst(rst), .load(tmr_load), .en(tmr_en), .load_val(tmr_val), .expired(expired)
  );
  // sequencing: abort overrides every busy state except DONE, which always returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? TGT_RST : IDLE;
      TGT_RST:   state_nx = expired ? WAIT_TRIG : TGT_RST;
      WAIT_TRIG: state_nx = target_trig ? BURST : expired ? NEXT : WAIT_TRIG;
`ifdef GLITCH_STOP_ON_HIT_EN
      OBSERVE:   state_nx = target_fault ? DONE : (target_ok || expired) ? NEXT : OBSERVE;
`else
      OBSERVE:   state_nx = (target_fault || target_ok || expired) ? NEXT : OBSERVE;
`endif
      BURST:     state_nx = expired ? OBSERVE : BURST;
      NEXT:      state_nx = last_pt ? DONE : TGT_RST;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (abort && state != IDLE && state != DONE) state_nx = DONE;
  end
  // campaign registers: latch on start, classify outcomes, step the sweep in NEXT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      glitch_delay <= '0;
      glitch_form <= '0;
      hit_count <= '0;
      timeout_count <= '0;
      last_hit_delay <= '0;
      step <= '0;
      pts <= '0;
      pt <= '0;
      reps_m1 <= '0;
      rep <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        glitch_delay <= cfg_delay_start;
        glitch_form <= cfg_form;
        step <= cfg_delay_step;
        pts <= cfg_delay_count == '0 ? 16'd1 : cfg_delay_count;
        reps_m1 <= cfg_repeats == '0 ? 8'd0 : cfg_repeats - 8'd1;
        hit_count <= '0;
        timeout_count <= '0;
        last_hit_delay <= '0;
        pt <= '0;
        rep <= '0;
      end
      if (hit) begin
        hit_count <= hit_count + 16'(hit_count != 16'hFFFF);
        last_hit_delay <= glitch_delay;
      end
      if (to_inc) timeout_count <= timeout_count + 16'(timeout_count != 16'hFFFF);
      if (state == NEXT && !abort) begin
        rep <= last_rep ? 8'd0 : rep + 8'd1;
        if (last_rep) begin
          glitch_delay <= glitch_delay + DELAY_W'(step);
          pt <= pt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// tb_glitch_sweep_ctrl: randomized and directed campaigns checked against an attempt-level timing/outcome model
module tb_glitch_sweep_ctrl;
  localparam int RC = 4, TT = 50, OC = 20, FW = 64;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [63:0] cfg_delay_start = 0;
  logic [31:0] cfg_delay_step = 0;
  logic [15:0] cfg_delay_count = 0;
  logic [7:0] cfg_repeats = 0;
  logic [63:0] cfg_form = 0;
  logic target_trig = 0, target_ok = 0, target_fault = 0;
  logic target_rst_n, glitch_trig, busy, done;
  logic [63:0] glitch_delay, glitch_form, last_hit_delay;
  logic [15:0] hit_count, timeout_count;
  int n_chk = 0, n_pass = 0;
  longint cyc = 0;
  int ta[64], rk[64], ra[64];

  glitch_sweep_ctrl #(.DELAY_W(64), .FORM_W(FW), .RST_CYCLES(RC), .TRIG_TIMEOUT(TT), .OBS_CYCLES(OC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_delay_start(cfg_delay_start), .cfg_delay_step(cfg_delay_step),
    .cfg_delay_count(cfg_delay_count), .cfg_repeats(cfg_repeats), .cfg_form(cfg_form),
    .target_trig(target_trig), .target_ok(target_ok), .target_fault(target_fault),
    .target_rst_n(target_rst_n), .glitch_trig(glitch_trig), .glitch_delay(glitch_delay),
    .glitch_form(glitch_form), .busy(busy), .done(done), .hit_count(hit_count),
    .timeout_count(timeout_count), .last_hit_delay(last_hit_delay)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_evt();
    int k = 0;
    while (target_rst_n && !done && k < 3000) begin
      adv();
      k++;
    end
  endtask

  task automatic fill(input int t, input int k, input int r);
    for (int i = 0; i < 64; i++) begin
      ta[i] = t;
      rk[i] = k;
      ra[i] = r;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      ta[i] = $urandom_range(0, 59);
      rk[i] = $urandom_range(0, 3);
      ra[i] = $urandom_range(0, 24);
    end
  endtask

  task automatic campaign(input logic [63:0] ds, input logic [31:0] st, input int cnt, input int rp);
    int np, nr, hits, tos, a, lo;
    bit stop, hit_stop, hit, ok;
    logic [63:0] d, lhd, fm, fin;
    longint exp_ev, w0, obs0;
    np = cnt == 0 ? 1 : cnt;
    nr = rp == 0 ? 1 : rp;
    hits = 0; tos = 0; a = 0; lhd = 0; stop = 0; hit_stop = 0;
    fm = {$urandom, $urandom};
    cfg_delay_start = ds; cfg_delay_step = st;
    cfg_delay_count = 16'(cnt); cfg_repeats = 8'(rp); cfg_form = fm;
    start = 1;
    exp_ev = cyc + 1;
    adv();
    start = 0;
    cfg_form = ~fm;
    for (int p = 0; p < np; p++)
      for (int r = 0; r < nr; r++)
        if (!stop) begin
          d = ds + 64'(p) * 64'(st);
          wait_evt();
          chk("attempt_start_time", 64'(cyc), 64'(exp_ev));
          if (target_rst_n) stop = 1;
          else begin
            lo = 0;
            while (!target_rst_n && lo < 100) begin
              target_trig = 1'($urandom);
              start = $urandom_range(0, 3) == 0;
              #1 chk("trig_gated_in_rst", glitch_trig, 0);
              adv();
              lo++;
            end
            target_trig = 0;
            start = 0;
            chk("rst_len", lo, RC);
            chk("delay", glitch_delay, d);
            if (a == 0) chk("form_latched", glitch_form, fm);
            w0 = cyc;
            if (ta[a] < TT) begin
              while (cyc < w0 + ta[a]) adv();
              target_trig = 1;
              #1 chk("trig_pass", glitch_trig, 1);
              adv();
              target_trig = 0;
              obs0 = w0 + ta[a] + 1 + longint'(d) + FW + 2;
              if (rk[a] != 0 && ra[a] < OC) begin
                while (cyc < obs0 + ra[a]) adv();
                target_ok = rk[a][0];
                target_fault = rk[a][1];
                adv();
                target_ok = 0;
                target_fault = 0;
              end
              hit = rk[a][1] && ra[a] < OC;
              ok = rk[a] == 1 && ra[a] < OC;
              if (hit) begin
                hits++;
                lhd = d;
              end else if (!ok) tos++;
              exp_ev = obs0 + ((rk[a] != 0 && ra[a] < OC) ? ra[a] : OC - 1) + 2;
`ifdef GLITCH_STOP_ON_HIT_EN
              if (hit) begin
                stop = 1;
                hit_stop = 1;
                exp_ev--;
              end
`endif
            end else begin
              tos++;
              exp_ev = w0 + TT + 1;
            end
            a++;
          end
        end
    fin = hit_stop ? lhd : ds + 64'(np) * 64'(st);
    wait_evt();
    chk("done_time", 64'(cyc), 64'(exp_ev));
    chk("done", done, 1);
    chk("hit_count", hit_count, 64'(hits));
    chk("timeout_count", timeout_count, 64'(tos));
    chk("last_hit_delay", last_hit_delay, lhd);
    chk("final_delay", glitch_delay, fin);
    adv();
    chk("idle_busy", busy, 0);
    chk("done_pulse", done, 0);
    repeat (2) adv();
  endtask

  initial begin
    repeat (3) adv();
    chk("rst_rstn", target_rst_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_delay", glitch_delay, 0);
    chk("rst_form", glitch_form, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_touts", timeout_count, 0);
    chk("rst_trig", glitch_trig, 0);
    rst = 0;
    adv();
    fill(3, 1, 0);
    campaign(64'd10, 32'd5, 3, 1);
    fill(3, 1, 0);
    rk[1] = 2;
    campaign(64'd10, 32'd5, 3, 1);
    fill(99, 0, 0);
    campaign(64'd10, 32'd5, 2, 1);
    fill(2, 3, 4);
    campaign(64'd7, 32'd1, 1, 1);
    fill(99, 0, 0);
    campaign(64'hFFFF_FFFF_FFFF_FFFD, 32'd5, 2, 1);
    fill(1, 1, 2);
    campaign(64'd3, 32'd4, 2, 0);
    fill(0, 0, 30);
    campaign(64'd0, 32'd2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      fill_rand();
      campaign(64'($urandom_range(0, 40)), 32'($urandom_range(0, 10)),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end
    // abort in BURST, with a start pulse that must be ignored
    cfg_delay_start = 5; cfg_delay_step = 1; cfg_delay_count = 3; cfg_repeats = 1;
    start = 1;
    adv();
    start = 0;
    wait_evt();
    while (!target_rst_n && busy) adv();
    target_trig = 1;
    adv();
    repeat (2) adv();
    abort = 1;
    start = 1;
    #1 chk("abort_rstn", target_rst_n, 1);
    chk("abort_trig", glitch_trig, 0);
    adv();
    abort = 0;
    start = 0;
    target_trig = 0;
    chk("abort_done", done, 1);
    chk("abort_busy_done", busy, 1);
    adv();
    chk("abort_idle", busy, 0);
    chk("abort_done_clr", done, 0);
    adv();
    chk("abort_start_ignored", busy, 0);
    // abort during target reset releases it combinationally
    start = 1;
    adv();
    start = 0;
    wait_evt();
    abort = 1;
    #1 chk("abort_tgtrst_rstn", target_rst_n, 1);
    adv();
    abort = 0;
    chk("abort_tgtrst_done", done, 1);
    adv();
    // abort in IDLE does nothing
    abort = 1;
    adv();
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);
    abort = 0;
    // reset mid-campaign
    start = 1;
    adv();
    start = 0;
    repeat (6) adv();
    rst = 1;
    adv();
    chk("midrst_busy", busy, 0);
    chk("midrst_rstn", target_rst_n, 1);
    chk("midrst_delay", glitch_delay, 0);
    rst = 0;
    adv();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/glitch_sweep_ctrl.md
Name: glitch_sweep_ctrl

Overview:
Campaign sequencer that drives the form glitcher across a delay sweep. Per attempt it:
- resets the target,
- arms the glitcher with the current delay and waveform,
- waits for the target trigger, the glitch burst, and an observation window,
- classifies the outcome and steps the delay.

It sits between the host register block and form_glitcher. It owns that block's form, delay and trigger-gating inputs.

Parameters:
DELAY_W, 64, width of the delay value passed to form_glitcher
FORM_W, 64, waveform width; also the burst length in cycles
RST_CYCLES, 1000, cycles target_rst_n is held low per attempt
TRIG_TIMEOUT, 1_000_000, maximum cycles waiting for a target trigger
OBS_CYCLES, 4096, observation window after the burst

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a campaign when idle
abort  in  1  level; ends the campaign at the next cycle
cfg_delay_start  in  DELAY_W  first delay
cfg_delay_step  in  32  delay increment, zero-extended
cfg_delay_count  in  16  number of delay points; 0 is treated as 1
cfg_repeats  in  8  attempts per delay point; 0 is treated as 1
cfg_form  in  FORM_W  waveform, sampled at start
target_trig  in  1  raw trigger from the target (already synchronised)
target_ok  in  1  target signals a normal run
target_fault  in  1  target signals anomalous output (glitch success)
target_rst_n  out  1  target reset, active low
glitch_trig  out  1  gated trigger to form_glitcher
glitch_delay  out  DELAY_W  current delay
glitch_form  out  FORM_W  latched waveform
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the campaign ends
hit_count  out  16  attempts classified as fault
timeout_count  out  16  attempts with no trigger or no response
last_hit_delay  out  DELAY_W  delay of the most recent hit

Behaviour:
- Reset values: all outputs 0 except target_rst_n=1. State is IDLE.
- IDLE + start: latch cfg_* into working registers. glitch_delay<=cfg_delay_start, counters<=0, go to TGT_RST.
- start while busy is ignored.
- TGT_RST: target_rst_n=0 for exactly RST_CYCLES cycles, then go to WAIT_TRIG.
- WAIT_TRIG:
  - glitch_trig = target_trig, combinationally gated by (state==WAIT_TRIG).
  - First cycle with target_trig=1: go to BURST.
  - TRIG_TIMEOUT cycles without a trigger: timeout_count++, go to NEXT.
- BURST: wait glitch_delay+FORM_W+2 cycles, which covers the edge-detect, delay and serializer pipeline. Then go to OBSERVE.
- glitch_delay is held stable from entering WAIT_TRIG until leaving BURST.
- OBSERVE, priority fault > ok > timeout:
  - target_fault: hit_count++, last_hit_delay<=glitch_delay.
  - target_ok: normal run, no counter change.
  - OBS_CYCLES elapse with neither: timeout_count++.
  - Every case exits to NEXT.
- NEXT (one cycle):
  - If the repeat counter < repeats-1: increment it.
  - Else: clear the repeat counter, add step to glitch_delay (wraps mod 2^DELAY_W), increment the point counter.
  - If the point counter reaches count: go to DONE. Else go to TGT_RST.
- DONE: done=1 for one cycle, then go to IDLE. Counters and last_hit_delay hold until the next start.
- abort: any busy state goes to DONE next cycle. target_rst_n returns to 1 and glitch_trig to 0 immediately. abort in IDLE has no effect.
- rst mid-campaign: immediate return to reset values.
- Saturation: hit_count and timeout_count saturate at 16'hFFFF.
- The cycle counter is 64-bit; the BURST compare uses the full width with no truncation.

Optional Feature:
Macro: GLITCH_STOP_ON_HIT_EN
- Defined: a fault classification in OBSERVE goes directly to DONE. The remaining sweep is skipped and last_hit_delay is the stopping point.
- Undefined: the sweep always runs to completion and all hits are counted.

Decomposition:
- Package glitch_pkg holds:
  - typedef enum logic [2:0] sweep_state_t {IDLE, TGT_RST, WAIT_TRIG, BURST, OBSERVE, NEXT, DONE}
  - localparams for the default widths
  - localparam BURST_PIPE_LAT = 2
- Sub-module cycle_timer: load value, en, expired flag, 64-bit down-counter. It is shared by TGT_RST, WAIT_TRIG, BURST and OBSERVE, reloaded on each state entry.

Test Plan:
- Use RST_CYCLES=4, TRIG_TIMEOUT=50, OBS_CYCLES=20 for all scenarios.
- start, delay_start=10, step=5, count=3, repeats=1; target raises trig 3 cycles after reset release, then target_ok -> glitch_delay sequence 10,15,20; done after the third attempt; hit_count=0, timeout_count=0.
- Same campaign; target_fault asserted in the 2nd observe window -> hit_count=1, last_hit_delay=15. With GLITCH_STOP_ON_HIT_EN defined, done follows that window and a third reset never occurs.
- target_trig never asserted, count=2 -> each attempt ends after 50 WAIT_TRIG cycles; timeout_count=2.
- target_trig asserted before reset is released (during TGT_RST) -> glitch_trig stays 0.
- target_fault and target_ok in the same cycle -> counted as a hit.
- abort asserted in BURST -> done the next cycle, target_rst_n=1, busy=0 the cycle after. A start during busy is ignored.
- delay_start=2^64-3, step=5, count=2 -> second delay is 2 (wrap-around).
- cfg_repeats=0 -> one attempt per point.
